pet_event_arbiter: RTL and testbench

//   Collects asynchronous-in-time event requests and hands them one at a time to the pet

---
 rtl/pet_event_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_pet_event_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pet_event_arbiter.sv
// pet_event_arbiter: queues and coalesces pet events from the buttons, the sensors and an
// internal decay tick, then hands them one at a time to the behaviour FSM over a
// valid/ready handshake. Grants that are never acknowledged are dropped after a timeout.
// Coalesced and timed-out events are counted in a saturating drop counter.
module pet_event_arbiter #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int TEST_DIV    = 5_000_000,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_heal,
    input  logic       req_feed,
    input  logic       req_play,
    input  logic       req_sleep,
    input  logic       test_mode,
    input  logic       evt_ready,
    input  logic       fsm_busy,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    output logic       time_tick,
    output logic [4:0] pending,
    output logic [7:0] drop_cnt
);

    localparam int MAX_DIV = (TICK_DIV > TEST_DIV) ? TICK_DIV : TEST_DIV;
    localparam int CNT_W   = $clog2(MAX_DIV + 1);
    localparam int WAIT_W  = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  TEST_LAST = CNT_W'(TEST_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_WAIT_BUSY = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   tick_cnt_r;
    logic               test_mode_r;
    logic               time_tick_r;
    logic [4:0]         pending_r;
    logic [7:0]         drop_cnt_r;
    logic               evt_valid_r;
    logic [2:0]         evt_code_r;
    logic [WAIT_W-1:0]  wait_cnt_r;

    logic [4:0]         req_vec_s;
    logic [4:0]         grant_mask_s;
    logic [2:0]         grant_code_s;
    logic [4:0]         coalesce_s;
    logic               timeout_s;
    logic [3:0]         drop_inc_s;
    logic [8:0]         drop_sum_s;
    logic [CNT_W-1:0]   tick_last_s;

    // Number of set bits in a 5-bit request vector (coalesce count for one cycle).
    function automatic logic [3:0] popcount5(input logic [4:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 5; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    assign evt_valid = evt_valid_r;
    assign evt_code  = evt_code_r;
    assign time_tick = time_tick_r;
    assign pending   = pending_r;
    assign drop_cnt  = drop_cnt_r;

    // The decay tick is itself a requester in the lowest-priority slot.
    assign req_vec_s = {time_tick_r, req_sleep, req_play, req_feed, req_heal};

    // Fixed-priority pick of the next event, only meaningful while idle with work queued.
    always_comb begin
        grant_mask_s = 5'b00000;
        grant_code_s = 3'd0;
        if (state_r == ST_IDLE && pending_r != 5'b00000) begin
            if (pending_r[0]) begin
                grant_mask_s = 5'b00001;
                grant_code_s = 3'd1;
            end else if (pending_r[1]) begin
                grant_mask_s = 5'b00010;
                grant_code_s = 3'd2;
            end else if (pending_r[2]) begin
                grant_mask_s = 5'b00100;
                grant_code_s = 3'd3;
            end else if (pending_r[3]) begin
                grant_mask_s = 5'b01000;
                grant_code_s = 3'd4;
            end else begin
                grant_mask_s = 5'b10000;
                grant_code_s = 3'd5;
            end
        end else begin
            grant_mask_s = 5'b00000;
            grant_code_s = 3'd0;
        end
    end

    // Drop accounting: a request hitting a still-queued bit is coalesced; a bit being granted
    // on this edge is consumed, so a new request for it re-queues instead.
    always_comb begin
        coalesce_s  = req_vec_s & pending_r & ~grant_mask_s;
        timeout_s   = (state_r == ST_GRANT) && !evt_ready && (wait_cnt_r == WAIT_LAST);
        drop_inc_s  = popcount5(coalesce_s) + {3'd0, timeout_s};
        drop_sum_s  = {1'b0, drop_cnt_r} + {5'd0, drop_inc_s};
        tick_last_s = test_mode ? TEST_LAST : TICK_LAST;
    end

    // Decay tick generator; a test_mode change restarts the period without a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_r  <= '0;
            test_mode_r <= 1'b0;
            time_tick_r <= 1'b0;
        end else begin
            test_mode_r <= test_mode;
            if (test_mode != test_mode_r) begin
                tick_cnt_r  <= '0;
                time_tick_r <= 1'b0;
            end else if (tick_cnt_r == tick_last_s) begin
                tick_cnt_r  <= '0;
                time_tick_r <= 1'b1;
            end else begin
                tick_cnt_r  <= tick_cnt_r + 1'b1;
                time_tick_r <= 1'b0;
            end
        end
    end

    // Pending queue and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_r  <= 5'b00000;
            drop_cnt_r <= 8'd0;
        end else begin
            pending_r <= (pending_r & ~grant_mask_s) | req_vec_s;
            if (drop_sum_s[8]) begin
                drop_cnt_r <= 8'hFF;
            end else begin
                drop_cnt_r <= drop_sum_s[7:0];
            end
        end
    end

    // Grant handshake FSM with registered valid/code and acknowledge timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            evt_valid_r <= 1'b0;
            evt_code_r  <= 3'd0;
            wait_cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wait_cnt_r <= '0;
                    if (pending_r != 5'b00000) begin
                        state_r     <= ST_GRANT;
                        evt_valid_r <= 1'b1;
                        evt_code_r  <= grant_code_s;
                    end else begin
                        evt_valid_r <= 1'b0;
                        evt_code_r  <= 3'd0;
                    end
                end
                ST_GRANT: begin
                    if (evt_ready) begin
                        state_r     <= ST_WAIT_BUSY;
                        evt_valid_r <= 1'b0;
                        evt_code_r  <= 3'd0;
                        wait_cnt_r  <= '0;
                    end else if (timeout_s) begin
                        state_r     <= ST_IDLE;
                        evt_valid_r <= 1'b0;
                        evt_code_r  <= 3'd0;
                        wait_cnt_r  <= '0;
                    end else begin
                        wait_cnt_r  <= wait_cnt_r + 1'b1;
                    end
                end
                ST_WAIT_BUSY: begin
                    evt_valid_r <= 1'b0;
                    evt_code_r  <= 3'd0;
                    if (!fsm_busy) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_BUSY;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    evt_valid_r <= 1'b0;
                    evt_code_r  <= 3'd0;
                    wait_cnt_r  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pet_event_arbiter.sv
// Directed testbench for pet_event_arbiter with hand-computed expected values.
module tb_pet_event_arbiter;

    logic       clk;
    logic       rst;
    logic       req_heal;
    logic       req_feed;
    logic       req_play;
    logic       req_sleep;
    logic       test_mode;
    logic       evt_ready;
    logic       fsm_busy;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       time_tick;
    logic [4:0] pending;
    logic [7:0] drop_cnt;

    int n_cmp;
    int n_bad;

    pet_event_arbiter #(
        .TICK_DIV   (5000),
        .TEST_DIV   (10),
        .ACK_TIMEOUT(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_heal (req_heal),
        .req_feed (req_feed),
        .req_play (req_play),
        .req_sleep(req_sleep),
        .test_mode(test_mode),
        .evt_ready(evt_ready),
        .fsm_busy (fsm_busy),
        .evt_valid(evt_valid),
        .evt_code (evt_code),
        .time_tick(time_tick),
        .pending  (pending),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (5) step();
        rst = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        req_heal = 1'b0;
        req_feed = 1'b0;
        req_play = 1'b0;
        req_sleep = 1'b0;
        test_mode = 1'b0;
        evt_ready = 1'b0;
        fsm_busy = 1'b0;

        // 1: reset state
        do_reset();
        check_val("rst_valid", 32'(evt_valid), 32'd0);
        check_val("rst_code", 32'(evt_code), 32'd0);
        check_val("rst_pending", 32'(pending), 32'd0);
        check_val("rst_drop", 32'(drop_cnt), 32'd0);
        check_val("rst_tick", 32'(time_tick), 32'd0);

        // 2: single feed, acknowledged immediately
        evt_ready = 1'b1;
        req_feed = 1'b1;
        step();
        req_feed = 1'b0;
        check_val("t2_pend", 32'(pending), 32'h02);
        check_val("t2_valid0", 32'(evt_valid), 32'd0);
        step();
        check_val("t2_valid", 32'(evt_valid), 32'd1);
        check_val("t2_code", 32'(evt_code), 32'd2);
        check_val("t2_pend_clr", 32'(pending), 32'h00);
        step();
        check_val("t2_valid_off", 32'(evt_valid), 32'd0);
        check_val("t2_code_off", 32'(evt_code), 32'd0);
        check_val("t2_pend_end", 32'(pending), 32'h00);
        step();

        // 3: heal and play together, FSM busy 3 cycles after each accept
        do_reset();
        evt_ready = 1'b1;
        req_heal = 1'b1;
        req_play = 1'b1;
        step();
        req_heal = 1'b0;
        req_play = 1'b0;
        check_val("t3_pend", 32'(pending), 32'h05);
        step();
        check_val("t3_v1", 32'(evt_valid), 32'd1);
        check_val("t3_c1", 32'(evt_code), 32'd1);
        check_val("t3_pend1", 32'(pending), 32'h04);
        step();
        fsm_busy = 1'b1;
        check_val("t3_hs1", 32'(evt_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t3_busy_gap", 32'(evt_valid), 32'd0);
        end
        fsm_busy = 1'b0;
        step();
        check_val("t3_idle_gap", 32'(evt_valid), 32'd0);
        step();
        check_val("t3_v2", 32'(evt_valid), 32'd1);
        check_val("t3_c2", 32'(evt_code), 32'd3);
        check_val("t3_pend2", 32'(pending), 32'h00);
        step();
        check_val("t3_hs2", 32'(evt_valid), 32'd0);
        step();

        // 4: heal granted, heal re-queued during grant, next heal coalesced
        do_reset();
        evt_ready = 1'b0;
        req_heal = 1'b1;
        step();
        req_heal = 1'b0;
        step();
        check_val("t4_grant", 32'(evt_code), 32'd1);
        check_val("t4_pend0", 32'(pending), 32'h00);
        req_heal = 1'b1;
        step();
        req_heal = 1'b0;
        check_val("t4_requeue", 32'(pending), 32'h01);
        check_val("t4_drop0", 32'(drop_cnt), 32'd0);
        check_val("t4_still_valid", 32'(evt_valid), 32'd1);
        req_heal = 1'b1;
        step();
        req_heal = 1'b0;
        check_val("t4_drop1", 32'(drop_cnt), 32'd1);
        check_val("t4_pend1", 32'(pending), 32'h01);
        evt_ready = 1'b1;
        step();
        check_val("t4_hs", 32'(evt_valid), 32'd0);
        step();
        step();
        check_val("t4_regrant", 32'(evt_valid), 32'd1);
        check_val("t4_regrant_code", 32'(evt_code), 32'd1);
        check_val("t4_pend_end", 32'(pending), 32'h00);
        step();

        // 5: acknowledge timeout after 16 cycles of valid
        do_reset();
        evt_ready = 1'b0;
        req_sleep = 1'b1;
        step();
        req_sleep = 1'b0;
        step();
        check_val("t5_valid", 32'(evt_valid), 32'd1);
        check_val("t5_code", 32'(evt_code), 32'd4);
        repeat (15) step();
        check_val("t5_valid_16", 32'(evt_valid), 32'd1);
        check_val("t5_drop_pre", 32'(drop_cnt), 32'd0);
        step();
        check_val("t5_valid_off", 32'(evt_valid), 32'd0);
        check_val("t5_drop", 32'(drop_cnt), 32'd1);
        evt_ready = 1'b1;
        req_feed = 1'b1;
        step();
        req_feed = 1'b0;
        step();
        check_val("t5_idle_regrant", 32'(evt_code), 32'd2);
        step();

        // 6: test-mode ticks, period restart, reset mid-grant
        do_reset();
        evt_ready = 1'b1;
        test_mode = 1'b1;
        step();
        check_val("t6_tick_e0", 32'(time_tick), 32'd0);
        repeat (9) step();
        check_val("t6_tick_e9", 32'(time_tick), 32'd0);
        step();
        check_val("t6_tick_e10", 32'(time_tick), 32'd1);
        step();
        check_val("t6_tick_e11", 32'(time_tick), 32'd0);
        check_val("t6_pend_tick", 32'(pending), 32'h10);
        step();
        check_val("t6_evt5_valid", 32'(evt_valid), 32'd1);
        check_val("t6_evt5_code", 32'(evt_code), 32'd5);
        repeat (8) step();
        check_val("t6_tick_e20", 32'(time_tick), 32'd1);
        repeat (3) step();
        test_mode = 1'b0;
        step();
        test_mode = 1'b1;
        step();
        repeat (5) step();
        check_val("t6_restart_e30", 32'(time_tick), 32'd0);
        repeat (5) step();
        check_val("t6_restart_e35", 32'(time_tick), 32'd1);
        repeat (5) step();
        evt_ready = 1'b0;
        req_feed = 1'b1;
        step();
        req_feed = 1'b0;
        step();
        check_val("t6_mid_grant", 32'(evt_valid), 32'd1);
        rst = 1'b0;
        #1;
        check_val("t6_rst_valid", 32'(evt_valid), 32'd0);
        check_val("t6_rst_code", 32'(evt_code), 32'd0);
        check_val("t6_rst_drop", 32'(drop_cnt), 32'd0);
        test_mode = 1'b0;
        step();
        rst = 1'b1;

        // 7: drop counter saturates under a continuous stream of coalesced heals
        do_reset();
        evt_ready = 1'b0;
        req_heal = 1'b1;
        repeat (300) step();
        req_heal = 1'b0;
        check_val("t7_saturate", 32'(drop_cnt), 32'd255);
        step();
        check_val("t7_hold", 32'(drop_cnt), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
